// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and requester IDs for the write-back arbiter
package regfile_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// regfile_wb_arbiter_wb_scoreboard: pending-write scoreboard with issue stall and operand hazards
//   clk, rst_n               clock, async active-low reset
//   issue_valid/issue_rd     reservation request; issue_ready accepts it
//   rs1, rs2                 decode operands; rs1_hazard/rs2_hazard flag pending writes
//   wr_en, wr_rd             registered RegFile write, clears the reservation it commits
module regfile_wb_arbiter_wb_scoreboard #(
  parameter int NREGS = regfile_wb_arbiter_pkg::NREGS,
  parameter int AW = regfile_wb_arbiter_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_hazard,
  output logic          rs2_hazard,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_rd
);
  logic [NREGS-1:0] busy, set_mask, clr_mask, busy_next;
  always_comb begin
    issue_ready = !(issue_rd != '0 && busy[issue_rd]);
    rs1_hazard = rs1 != '0 && busy[rs1];
    rs2_hazard = rs2 != '0 && busy[rs2];
    set_mask = (issue_valid && issue_ready && issue_rd != '0) ? NREGS'(1) << issue_rd : '0;
    clr_mask = (wr_en && wr_rd != '0) ? NREGS'(1) << wr_rd : '0;
    // set is applied after clear so a new producer survives a same-edge commit
    busy_next = ((busy & ~clr_mask) | set_mask) & ~NREGS'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_next;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU write-back arbiter driving the RegFile write port
//   clk, rst_n                    clock, async active-low reset
//   issue_*, rs1/rs2, *_hazard    scoreboard reservation and operand hazard interface
//   alu_valid/ready/rd/data       ALU write-back request
//   lsu_valid/ready/rd/data       LSU write-back request
//   RegWrite, rd, rd_write_data   registered RegFile write port
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int NREGS = regfile_wb_arbiter_pkg::NREGS,
  parameter int AW = regfile_wb_arbiter_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_hazard,
  output logic            rs2_hazard,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            RegWrite,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] rd_write_data
);
  import regfile_wb_arbiter_pkg::*;
  logic last_grant, grant;
  logic [AW-1:0] g_rd;
  logic [XLEN-1:0] g_data;
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || last_grant == REQ_LSU);
    lsu_ready = lsu_valid && !alu_ready;
    grant = alu_ready || lsu_ready;
    g_rd = alu_ready ? alu_rd : lsu_rd;
    g_data = alu_ready ? alu_data : lsu_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      RegWrite <= 1'b0;
      rd <= '0;
      rd_write_data <= '0;
      last_grant <= REQ_LSU;
    end else begin
      RegWrite <= grant && g_rd != '0;
      if (grant) begin
        rd <= g_rd;
        rd_write_data <= g_data;
        last_grant <= alu_ready ? REQ_ALU : REQ_LSU;
      end
    end
  regfile_wb_arbiter_wb_scoreboard #(.NREGS(NREGS), .AW(AW)) u_wb_scoreboard (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_hazard(rs1_hazard),
    .rs2_hazard(rs2_hazard),
    .wr_en(RegWrite),
    .wr_rd(rd)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector bench for the write-back arbiter and scoreboard
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid = 1'b0, issue_ready;
  logic [4:0] issue_rd = '0, rs1 = '0, rs2 = '0;
  logic rs1_hazard, rs2_hazard;
  logic alu_valid = 1'b0, alu_ready, lsu_valid = 1'b0, lsu_ready;
  logic [4:0] alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic RegWrite;
  logic [4:0] rd;
  logic [31:0] rd_write_data;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .rd(rd), .rd_write_data(rd_write_data)
  );

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
    logic e_ar, e_lr, e_ir, e_h1, e_h2, e_rw; logic [4:0] e_rd; logic [31:0] e_d;
  } vec_t;

  vec_t v [19];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{1, 3, 32'hAAAA, 1, 4, 32'hBBBB, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 3, 32'hAAAA};
    v[1]  = '{1, 3, 32'hAAAA, 1, 4, 32'hBBBB, 0, 0, 0, 0,  0, 1, 1, 0, 0, 1, 4, 32'hBBBB};
    v[2]  = '{1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0,         1, 0, 1, 0, 0, 1, 5, 32'h1234};
    v[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 1, 0, 0, 0, 5, 32'h1234};
    v[4]  = '{0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0,         0, 1, 1, 0, 0, 0, 0, 32'hDEAD};
    v[5]  = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 0,                0, 0, 1, 0, 0, 0, 0, 32'hDEAD};
    v[6]  = '{0, 0, 0, 1, 7, 32'h77, 0, 7, 7, 0,           0, 1, 0, 1, 0, 1, 7, 32'h77};
    v[7]  = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 0,                0, 0, 0, 1, 0, 0, 7, 32'h77};
    v[8]  = '{0, 0, 0, 0, 0, 0, 0, 7, 7, 0,                0, 0, 1, 0, 0, 0, 7, 32'h77};
    v[9]  = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 9,                0, 0, 1, 0, 0, 0, 7, 32'h77};
    v[10] = '{0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9,           0, 1, 0, 0, 1, 1, 9, 32'h99};
    v[11] = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 9,                0, 0, 0, 0, 1, 0, 9, 32'h99};
    v[12] = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 9,                0, 0, 1, 0, 0, 0, 9, 32'h99};
    v[13] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 9,                0, 0, 0, 0, 1, 0, 9, 32'h99};
    v[14] = '{1, 12, 32'hC, 0, 0, 0, 0, 12, 0, 0,          1, 0, 1, 0, 0, 1, 12, 32'hC};
    v[15] = '{0, 0, 0, 0, 0, 0, 1, 12, 12, 0,              0, 0, 1, 0, 0, 0, 12, 32'hC};
    v[16] = '{0, 0, 0, 0, 0, 0, 0, 12, 12, 0,              0, 0, 0, 1, 0, 0, 12, 32'hC};
    v[17] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0,      0, 1, 1, 0, 0, 1, 2, 32'h22};
    v[18] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0,      1, 0, 1, 0, 0, 1, 1, 32'h11};

    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 0, 32'(RegWrite), 0);
    chk("rst_rd", 0, 32'(rd), 0);
    chk("rst_data", 0, rd_write_data, 0);
    @(negedge clk);
    rst_n = 1'b1; alu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_regwrite", 0, 32'(RegWrite), 0);

    for (int i = 0; i < 19; i++) begin
      alu_valid = v[i].av; alu_rd = v[i].ard; alu_data = v[i].ad;
      lsu_valid = v[i].lv; lsu_rd = v[i].lrd; lsu_data = v[i].ld;
      issue_valid = v[i].iv; issue_rd = v[i].ird; rs1 = v[i].r1; rs2 = v[i].r2;
      #1;
      chk("alu_ready", i, 32'(alu_ready), 32'(v[i].e_ar));
      chk("lsu_ready", i, 32'(lsu_ready), 32'(v[i].e_lr));
      chk("issue_ready", i, 32'(issue_ready), 32'(v[i].e_ir));
      chk("rs1_hazard", i, 32'(rs1_hazard), 32'(v[i].e_h1));
      chk("rs2_hazard", i, 32'(rs2_hazard), 32'(v[i].e_h2));
      @(posedge clk);
      #1;
      chk("regwrite", i, 32'(RegWrite), 32'(v[i].e_rw));
      chk("rd", i, 32'(rd), 32'(v[i].e_rd));
      chk("rd_write_data", i, rd_write_data, v[i].e_d);
    end

    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_regwrite", 0, 32'(RegWrite), 0);
    chk("async_rst_rd", 0, 32'(rd), 0);
    chk("async_rst_data", 0, rd_write_data, 0);
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(r); issue_rd = 5'(r);
      #1;
      chk("rst_busy_rs1", r, 32'(rs1_hazard), 0);
      chk("rst_busy_rs2", r, 32'(rs2_hazard), 0);
      chk("rst_issue_ready", r, 32'(issue_ready), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_regwrite", 0, 32'(RegWrite), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Single-clock controller that shares the one RegFile write port between two write-back requesters: ALU and load/store unit (LSU).
- Keeps a pending-write scoreboard: issue stage reserves a destination register; operand hazards are flagged until the write commits.
- Sits between execute/memory stages and RegFile; drives RegWrite, rd and rd_write_data.

Parameters:
- XLEN, 32, data width
- NREGS, 32, number of architectural registers (x0 hardwired zero)
- AW, 5, register address width, log2(NREGS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  issue stage wants to reserve issue_rd
- issue_ready  out  1  reservation accepted this cycle
- issue_rd  in  AW  destination of the issuing instruction
- rs1, rs2  in  AW  operand addresses of the instruction in decode
- rs1_hazard, rs2_hazard  out  1  operand has a pending write
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result granted
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result available
- lsu_ready  out  1  load result granted
- lsu_rd  in  AW  load destination
- lsu_data  in  XLEN  load result
- RegWrite  out  1  RegFile write enable (registered)
- rd  out  AW  RegFile write address (registered)
- rd_write_data  out  XLEN  RegFile write data (registered)

Behaviour:
- Reset, asynchronous on rst_n low: RegWrite=0, rd=0, rd_write_data=0, busy[NREGS-1:0]=0, last_grant=LSU (so ALU wins the first tie). Reset mid-transfer drops any registered write and clears all reservations.
- Arbitration is combinational within the cycle.
  - Only one of ALU/LSU valid: that requester gets ready=1.
  - Both valid: round-robin; grant the requester not in last_grant.
  - last_grant updates only on a grant.
  - At most one ready high per cycle. Handshake completes when valid && ready.
  - Requesters hold valid, rd and data stable until ready.
- Write-back latency is 1 cycle. The granted rd/data are captured at the clock edge.
  - Next cycle: RegWrite=1 if captured rd!=0, else RegWrite=0.
  - With no grant, RegWrite=0 next cycle; rd and rd_write_data hold their last values.
  - A grant is possible every cycle (full throughput, no bubbles).
- Scoreboard:
  - busy[r] sets on issue_valid && issue_ready && issue_rd==r, r!=0.
  - busy[r] clears at the edge where RegWrite=1 && rd==r, i.e. the same edge at which RegFile stores the value.
  - Set and clear of the same r on the same edge: set wins (new producer).
  - busy[0] is constantly 0.
- issue_ready = !(issue_rd!=0 && busy[issue_rd]). This stalls a WAW issue until the older write commits. A register being cleared this edge still counts as busy for that cycle.
- rs1_hazard = rs1!=0 && busy[rs1]; rs2_hazard likewise. Combinational from the current busy. No forwarding in this block.
- A write-back to rd=0 is accepted (ready=1) but produces no RegWrite and no scoreboard change.
- A write-back to a non-busy register is legal: it is written, and busy stays 0.

Decomposition:
- Shared package: XLEN, NREGS, AW, and the requester-ID constants (REQ_ALU=0, REQ_LSU=1) used for last_grant.
- One natural sub-module: wb_scoreboard. It holds busy[], the set/clear logic, issue_ready and the hazard outputs.
- The round-robin grant and the output register stay in the top module.

Test Plan:
- Reset then idle: rst_n low with alu_valid=1 -> RegWrite=0, busy all 0, alu_ready ignored. After release, first ALU write x5=0x1234 -> RegWrite=1, rd=5, rd_write_data=0x1234 exactly one cycle later.
- Contention: ALU (x3=0xAAAA) and LSU (x4=0xBBBB) both valid for 2 cycles from reset -> cycle 1 grants ALU, cycle 2 grants LSU. Writes appear back-to-back: x3 then x4.
- Scoreboard hazard: issue x7, then decode rs1=7 -> rs1_hazard=1 until the cycle after RegWrite=1/rd=7, then 0. rs2=0 -> rs2_hazard=0 always.
- WAW stall: x9 busy, issue_valid with issue_rd=9 -> issue_ready=0. LSU writes x9 -> issue_ready=1 in the cycle after RegWrite with rd=9.
- Same-edge set/clear: RegWrite for x12 on the edge where a new issue of x12 is accepted -> busy[12] stays 1.
- x0 and reset mid-op: LSU write to x0 -> lsu_ready=1, RegWrite=0. rst_n asserted while RegWrite=1 -> RegWrite drops to 0 immediately (asynchronously), busy all 0.
